// File: rtl/fifo_multimode.sv
// Synchronous FIFO with a standard registered-read mode and a first-word-fall-through mode.
// In FWFT mode the head word sits in the dout register; count includes that word.
module fifo_multimode #(
   parameter int DATA_WIDTH   = 64,
   parameter int ADDR_WIDTH   = 5,
   parameter int FWFT         = 0,
   parameter int AFULL_LEVEL  = (1 << ADDR_WIDTH) - 2,
   parameter int AEMPTY_LEVEL = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] din,
   input  logic                  rd_en,
   input  logic                  clr_err,
   output logic [DATA_WIDTH-1:0] dout,
   output logic                  dout_valid,
   output logic                  full,
   output logic                  empty,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  overflow,
   output logic                  underflow
);

   localparam int DEPTH = 1 << ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] DEPTH_CNT  = (ADDR_WIDTH + 1)'(DEPTH);
   localparam logic [ADDR_WIDTH:0] AFULL_CNT  = (ADDR_WIDTH + 1)'(AFULL_LEVEL);
   localparam logic [ADDR_WIDTH:0] AEMPTY_CNT = (ADDR_WIDTH + 1)'(AEMPTY_LEVEL);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
   logic [ADDR_WIDTH:0]   count_next, mem_count;
   logic                  wr_acc, rd_acc, mem_rd, mem_wr, bypass, load_out;
   logic                  dout_valid_next, ovf_evt, unf_evt;

   assign full    = (count == DEPTH_CNT);
   assign empty   = (FWFT != 0) ? !dout_valid : (count == '0);
   assign ovf_evt = wr_en && full;
   assign unf_evt = (FWFT == 0) && rd_en && empty;

   // NOTE: every signal gets a default before any branch so no path leaves it unassigned (no latches).
   always_comb begin
      wr_acc          = wr_en && !full;
      rd_acc          = 1'b0;
      mem_rd          = 1'b0;
      mem_wr          = 1'b0;
      bypass          = 1'b0;
      load_out        = 1'b0;
      dout_valid_next = 1'b0;
      mem_count       = count;
      if (FWFT != 0) begin
         // Words in the array exclude the one already presented on dout.
         mem_count       = count - {{ADDR_WIDTH{1'b0}}, dout_valid};
         rd_acc          = rd_en && dout_valid;
         load_out        = !dout_valid || rd_acc;
         mem_rd          = load_out && (mem_count != '0);
         bypass          = load_out && (mem_count == '0) && wr_acc;
         mem_wr          = wr_acc && !bypass;
         dout_valid_next = load_out ? (mem_rd || bypass) : 1'b1;
      end else begin
         rd_acc          = rd_en && !empty;
         mem_rd          = rd_acc;
         mem_wr          = wr_acc;
         dout_valid_next = rd_acc;
      end
      unique case ({wr_acc, rd_acc})
         2'b10:   count_next = count + 1'b1;
         2'b01:   count_next = count - 1'b1;
         default: count_next = count;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         almost_full  <= 1'b0;
         almost_empty <= 1'b1;
         overflow     <= 1'b0;
         underflow    <= 1'b0;
         dout         <= '0;
         dout_valid   <= 1'b0;
      end else begin
         if (mem_wr) wr_ptr <= wr_ptr + 1'b1;
         if (mem_rd) rd_ptr <= rd_ptr + 1'b1;
         count        <= count_next;
         almost_full  <= (count_next >= AFULL_CNT);
         almost_empty <= (count_next <= AEMPTY_CNT);
         // An error in the same cycle as clr_err wins over the clear.
         overflow     <= ovf_evt || (overflow && !clr_err);
         underflow    <= unf_evt || (underflow && !clr_err);
         if (mem_rd)      dout <= mem[rd_ptr];
         else if (bypass) dout <= din;
         dout_valid   <= dout_valid_next;
      end
   end

   // NOTE: the storage array has no reset so it maps onto RAM; count and pointers define validity.
   always_ff @(posedge clk) begin
      if (mem_wr) mem[wr_ptr] <= din;
   end

endmodule

// File: doc/fifo_multimode.md
FIFO_MULTIMODE -- requirements
Module: fifo_multimode

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, word width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 5, giving DEPTH = 2^ADDR_WIDTH words; legal range 2..12.
REQ-003 SHALL have parameter FWFT, default 0; 0 = standard read with 1-cycle registered output, 1 = first-word-fall-through.
REQ-004 SHALL have parameter AFULL_LEVEL, default DEPTH-2, almost-full threshold; legal range 1..DEPTH.
REQ-005 SHALL have parameter AEMPTY_LEVEL, default 2, almost-empty threshold; legal range 0..DEPTH-1.
REQ-006 clk  input  1  clock; all logic on rising edge.
REQ-007 rst_n  input  1  reset, asynchronous, active-low.
REQ-008 wr_en  input  1  write request.
REQ-009 din  input  DATA_WIDTH  write data, sampled with wr_en.
REQ-010 rd_en  input  1  read request (FWFT=1: pop of the presented word).
REQ-011 clr_err  input  1  synchronous clear of sticky error flags.
REQ-012 dout  output  DATA_WIDTH  read data.
REQ-013 dout_valid  output  1  dout holds a valid word (meaning per mode, REQ-021/REQ-023).
REQ-014 full, empty  output  1 each  occupancy flags.
REQ-015 almost_full, almost_empty  output  1 each  threshold flags.
REQ-016 count  output  ADDR_WIDTH+1  words held, 0..DEPTH.
REQ-017 overflow, underflow  output  1 each  sticky error flags.

Function
REQ-018 Capacity SHALL be exactly DEPTH words in both modes; count SHALL include any word held in the FWFT output stage.
REQ-019 Write SHALL be accepted at an edge iff wr_en=1 and registered full=0; a same-cycle rd_en SHALL NOT allow a write into a full FIFO.
REQ-020 Rejected write (wr_en=1, full=1) SHALL leave contents and count unchanged and set overflow at that edge.
REQ-021 FWFT=0: read accepted iff rd_en=1 and empty=0; at that edge dout takes the oldest word and dout_valid=1 for exactly the following cycle; otherwise dout holds its value and dout_valid=0.
REQ-022 FWFT=0: rd_en=1 with empty=1 SHALL change no state except setting underflow.
REQ-023 FWFT=1: dout SHALL present the oldest word whenever dout_valid=1; pop accepted iff rd_en=1 and dout_valid=1; rd_en with dout_valid=0 SHALL be ignored and SHALL NOT set underflow.
REQ-024 FWFT=1: word accepted into an empty FIFO at edge k SHALL give dout_valid=1 from edge k+1; back-to-back pops SHALL sustain one word per cycle while count>=2.
REQ-025 empty SHALL equal (count==0) for FWFT=0 and (dout_valid==0) for FWFT=1; full SHALL equal (count==DEPTH).
REQ-026 count SHALL change by +1 (write only), -1 (read only), 0 (both or neither) per edge; never wraps past 0 or DEPTH.
REQ-027 almost_full SHALL be registered (count >= AFULL_LEVEL); almost_empty registered (count <= AEMPTY_LEVEL); both from next-state count, no extra cycle lag.
REQ-028 Storage pointers SHALL wrap modulo DEPTH; ordering SHALL be strictly first-in-first-out across wrap.
REQ-029 Simultaneous accepted write and read SHALL keep count constant, including at count=1 in FWFT=0 and at count=DEPTH-1.
REQ-030 overflow/underflow SHALL stay set until clr_err=1; an error event in the same cycle as clr_err SHALL leave the flag set.
REQ-031 Storage SHALL be inferable as RAM (no reset on storage array); only control, flags, dout, dout_valid reset.

Reset
REQ-032 While rst_n=0: count=0, empty=1, full=0, almost_empty=1, almost_full=0, dout=0, dout_valid=0, overflow=0, underflow=0, pointers 0.
REQ-033 Reset asserted mid-operation SHALL discard all stored words immediately; first write after release SHALL be the first word read.

Verification
REQ-034 FWFT=0, ADDR_WIDTH=2: write 0x1,0x2,0x3,0x4 -> full=1,count=4; fifth write 0x5 -> overflow=1, 4 reads return 0x1..0x4 each one cycle after rd_en, then empty=1.
REQ-035 FWFT=1: single write 0xAA at edge k -> dout_valid=1,dout=0xAA from k+1; rd_en at k+1 -> dout_valid=0,count=0 at k+2, underflow stays 0.
REQ-036 FWFT=0: rd_en on empty -> underflow=1, dout unchanged; clr_err pulse -> underflow=0.
REQ-037 Both modes, DEPTH=32, AFULL_LEVEL=30, AEMPTY_LEVEL=2: fill to 30 -> almost_full=1 same edge count=30; drain to 2 -> almost_empty=1.
REQ-038 Continuous simultaneous write/read for 100 cycles at count=16 (incl. pointer wrap) -> count stays 16, output sequence equals input sequence.
REQ-039 rst_n pulsed low with count=10 -> all outputs at REQ-032 values asynchronously; next write/read returns the new word.
